mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory stage of the Y86-64 SEQ datapath, downstream of execute.
- Consumes the execute result `valE` together with `valA`/`valP`/`icode`, and performs at most one 64-bit data-memory access per instruction.
- Talks to the data memory over a req/ack handshake.
- Returns `valM` and a `dmem_error` flag to writeback and status logic, framed by a start/done handshake with the control sequencer.

Parameters:
- MEM_SIZE, 8192, number of addressable data-memory bytes; valid access iff addr <= MEM_SIZE-8.
- TIMEOUT_CYC, 16, max cycles `mem_req` is held without `mem_ack` before the access is aborted as an error.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; `icode`/`valE`/`valA`/`valP` valid this cycle
- icode  in  4  instruction code
- valE  in  64  ALU result from execute
- valA  in  64  register operand A
- valP  in  64  incremented PC
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- valM  out  64  read data; held until next accepted start
- dmem_error  out  1  invalid address or timeout; held until next accepted start
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  64  byte address; valid while mem_req
- mem_wdata  out  64  write data; valid while mem_req && mem_we
- mem_ack  in  1  memory accepts the access / read data valid this cycle
- mem_rdata  in  64  read data, sampled when mem_ack

Behaviour:
- Reset (async): state IDLE; busy, done, mem_req, mem_we, dmem_error = 0; valM, mem_addr, mem_wdata, timeout counter = 0. Reset mid-access drops mem_req immediately, with no done pulse.
- Access decode on start:
  - icode 4 (rmmovq): write, addr = valE, data = valA.
  - icode 5 (mrmovq): read, addr = valE.
  - icode 8 (call): write, addr = valE, data = valP.
  - icode 10 (pushq): write, addr = valE, data = valA.
  - icode 9 (ret), 11 (popq): read, addr = valA.
  - All other icodes: no access.
- FSM states: IDLE, ACCESS, FINISH.
- IDLE, start = 1:
  - Latch decode results.
  - Clear valM and dmem_error.
  - No access → FINISH.
  - Access with addr > MEM_SIZE-8 (unsigned compare, no addition, so addresses near 2^64 cannot wrap) → set dmem_error, FINISH, no mem_req.
  - Otherwise → ACCESS.
- ACCESS:
  - mem_req = 1; mem_we/mem_addr/mem_wdata stable.
  - Counter increments each cycle mem_ack = 0.
  - mem_ack = 1: on a read, valM <= mem_rdata; → FINISH.
  - Counter reaches TIMEOUT_CYC-1 with no ack: set dmem_error, valM unchanged (0); → FINISH.
- FINISH: done = 1 for exactly one cycle; → IDLE.
- Registered outputs: mem_req falls the cycle after ack; mem_req is never asserted in the same cycle as start.
- Latency, start sampled at edge 0:
  - No-access instruction: done at cycle 1.
  - Address error: done at cycle 1.
  - Normal access: mem_req high in cycles 1..k, where k is the first cycle mem_ack is sampled high; done at cycle k+1.
  - Timeout: done at cycle TIMEOUT_CYC+1.
- busy = (state != IDLE). start while busy is ignored, with no side effects.
- start in the same cycle as done (FINISH) is ignored; the sequencer waits for IDLE.
- mem_ack or mem_rdata outside ACCESS is ignored.

Decomposition:
- Shared package y86_pkg:
  - icode constants IHALT..IPOPQ (0..11).
  - Stat codes SAOK=1, SHLT=2, SADR=3, SINS=4.
  - FSM state typedef.
- One combinational sub-module mem_ctrl: icode/valE/valA/valP → is_rd, is_wr, addr, wdata. Shared later with the PIPE memory stage.

Test Plan:
- Reset then idle → all outputs 0; start with icode=6 (OPq) → done at cycle 1, mem_req never high, dmem_error=0.
- icode=4, valE=0x100, valA=0xDEADBEEF, mem_ack returned 2 cycles after mem_req → mem_req/mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF for 3 cycles; done the next cycle.
- icode=11 (popq), valA=0x1F8, ack in first req cycle with rdata=0x1234 → mem_we=0, mem_addr=0x1F8, valM=0x1234, done at cycle 2.
- icode=5, valE=MEM_SIZE-7; then valE=0xFFFF_FFFF_FFFF_FFFC → dmem_error=1, done at cycle 1, no mem_req in either case; valE=MEM_SIZE-8 → normal access.
- icode=8 (call), valP=0x40, mem_ack held 0 → mem_req high exactly TIMEOUT_CYC cycles, then dmem_error=1 with done; a second start during busy is ignored.
- Assert rst during ACCESS (icode=10) → mem_req drops without waiting for a clock edge, no done, all outputs 0; the next start behaves normally.

Source files
------------

// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared Y86-64 definitions used by the SEQ memory stage (and later by the
// PIPE memory stage):
//   - instruction codes IHALT..IPOPQ
//   - processor status codes
//   - memory-stage FSM state type and state encodings
// ---------------------------------------------------------------------------
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'd0;
    localparam logic [3:0] INOP    = 4'd1;
    localparam logic [3:0] IRRMOVQ = 4'd2;
    localparam logic [3:0] IIRMOVQ = 4'd3;
    localparam logic [3:0] IRMMOVQ = 4'd4;
    localparam logic [3:0] IMRMOVQ = 4'd5;
    localparam logic [3:0] IOPQ    = 4'd6;
    localparam logic [3:0] IJXX    = 4'd7;
    localparam logic [3:0] ICALL   = 4'd8;
    localparam logic [3:0] IRET    = 4'd9;
    localparam logic [3:0] IPUSHQ  = 4'd10;
    localparam logic [3:0] IPOPQ   = 4'd11;

    // Processor status codes
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    // Memory-stage FSM
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_FINISH = 2'd2;

endpackage

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
// Purely combinational access decode for the Y86-64 memory stage.
// Ports:
//   i_icode  in  4   instruction code
//   i_valE   in  64  ALU result (address for most accesses)
//   i_valA   in  64  register operand A (write data, or address for ret/popq)
//   i_valP   in  64  incremented PC (write data for call)
//   o_is_rd  out 1   instruction reads data memory
//   o_is_wr  out 1   instruction writes data memory
//   o_addr   out 64  byte address of the access
//   o_wdata  out 64  write data
// ---------------------------------------------------------------------------
module mem_ctrl
    import y86_pkg::*;
(
    input  logic [3:0]  i_icode,
    input  logic [63:0] i_valE,
    input  logic [63:0] i_valA,
    input  logic [63:0] i_valP,
    output logic        o_is_rd,
    output logic        o_is_wr,
    output logic [63:0] o_addr,
    output logic [63:0] o_wdata
);

    always_comb begin
        o_is_rd = 1'b0;
        o_is_wr = 1'b0;
        o_addr  = i_valE;
        o_wdata = i_valA;
        case (i_icode)
            IRMMOVQ, IPUSHQ: begin
                o_is_wr = 1'b1;
            end
            ICALL: begin
                o_is_wr = 1'b1;
                o_wdata = i_valP;
            end
            IMRMOVQ: begin
                o_is_rd = 1'b1;
            end
            // ret and popq read from the old stack pointer, which arrives on valA
            IRET, IPOPQ: begin
                o_is_rd = 1'b1;
                o_addr  = i_valA;
            end
            default: begin
                o_is_rd = 1'b0;
                o_is_wr = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
// Memory stage of the Y86-64 SEQ datapath. Performs at most one 64-bit
// data-memory access per instruction over a req/ack handshake, framed by a
// start/done handshake with the control sequencer.
//
// Handshakes:
//   start/done : start is a one-cycle pulse accepted only in IDLE (busy=0).
//                done pulses for exactly one cycle when the result is ready;
//                valM and dmem_error stay valid until the next accepted start.
//   req/ack    : mem_req rises the cycle after start and holds with stable
//                mem_we/mem_addr/mem_wdata until mem_ack is sampled high, or
//                until TIMEOUT_CYC cycles pass without ack (access aborted).
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   start                 one-cycle start pulse, operands valid this cycle
//   icode/valE/valA/valP  instruction operands from execute
//   busy                  high while the FSM is not IDLE
//   done                  one-cycle completion pulse
//   valM                  read data
//   dmem_error            invalid address or timeout
//   mem_req/mem_we/mem_addr/mem_wdata   request side to data memory
//   mem_ack/mem_rdata     response side from data memory
//   dbg_state             current FSM state, for observation only
// ---------------------------------------------------------------------------
module mem_access
    import y86_pkg::*;
#(
    parameter int MEM_SIZE    = 8192,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        busy,
    output logic        done,
    output logic [63:0] valM,
    output logic        dmem_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    // Highest legal start address of an 8-byte access. Comparing against
    // this (instead of computing addr+8) cannot overflow near 2^64.
    localparam logic [63:0] LAST_ADDR = 64'(MEM_SIZE - 8);
    localparam int          CNT_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic        w_is_rd;
    logic        w_is_wr;
    logic [63:0] w_addr;
    logic [63:0] w_wdata;

    state_t           r_state;
    logic             r_is_rd;
    logic             r_we;
    logic [63:0]      r_addr;
    logic [63:0]      r_wdata;
    logic [63:0]      r_valm;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    mem_ctrl u_mem_ctrl (
        .i_icode (icode),
        .i_valE  (valE),
        .i_valA  (valA),
        .i_valP  (valP),
        .o_is_rd (w_is_rd),
        .o_is_wr (w_is_wr),
        .o_addr  (w_addr),
        .o_wdata (w_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_is_rd <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_valm  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_is_rd <= w_is_rd;
                        r_we    <= w_is_wr;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_valm  <= '0;
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                        if (!(w_is_rd || w_is_wr)) begin
                            r_state <= ST_FINISH;
                        end else if (w_addr > LAST_ADDR) begin
                            // Bad address: report without ever raising mem_req
                            r_err   <= 1'b1;
                            r_state <= ST_FINISH;
                        end else begin
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        if (r_is_rd) begin
                            r_valm <= mem_rdata;
                        end
                        r_state <= ST_FINISH;
                    end else if (r_cnt == CNT_LAST) begin
                        // Counter holds k-1 in request cycle k, so this fires
                        // after exactly TIMEOUT_CYC unacknowledged cycles.
                        r_err   <= 1'b1;
                        r_state <= ST_FINISH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from state flops so reset clears them at once.
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_FINISH);
    assign mem_req    = (r_state == ST_ACCESS);
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign valM       = r_valm;
    assign dmem_error = r_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access
// Directed testbench for mem_access. Inputs change just after the falling
// edge and outputs are checked mid-cycle, so "cycle n" below means the
// interval right after rising edge n-1 (start is sampled at edge 0).
// ---------------------------------------------------------------------------
module tb_mem_access;

    localparam int MEM_SIZE    = 8192;
    localparam int TIMEOUT_CYC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [63:0] valP;
    logic        busy;
    logic        done;
    logic [63:0] valM;
    logic        dmem_error;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic [1:0]  dbg_state;

    int vectors    = 0;
    int miscompares = 0;

    logic [63:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mem_access #(
        .MEM_SIZE    (MEM_SIZE),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .icode      (icode),
        .valE       (valE),
        .valA       (valA),
        .valP       (valP),
        .busy       (busy),
        .done       (done),
        .valM       (valM),
        .dmem_error (dmem_error),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    // Pulse start for one cycle; returns in the middle of cycle 1.
    task automatic do_start(input logic [3:0] ic, input logic [63:0] e,
                            input logic [63:0] a, input logic [63:0] p);
        @(negedge clk);
        start = 1'b1;
        icode = ic;
        valE  = e;
        valA  = a;
        valP  = p;
        @(negedge clk);
        start = 1'b0;
        icode = 4'($urandom_range(0, 15));
        valE  = {$urandom, $urandom};
        valA  = {$urandom, $urandom};
        valP  = {$urandom, $urandom};
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  64'(busy),       64'd0);
        check({tag, "_done"},  64'(done),       64'd0);
        check({tag, "_req"},   64'(mem_req),    64'd0);
        check({tag, "_we"},    64'(mem_we),     64'd0);
        check({tag, "_addr"},  mem_addr,        64'd0);
        check({tag, "_wdata"}, mem_wdata,       64'd0);
        check({tag, "_valm"},  valM,            64'd0);
        check({tag, "_err"},   64'(dmem_error), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int req_cycles;
        int done_cyc;
        logic [63:0] exp_v;

        rst       = 1'b1;
        start     = 1'b0;
        icode     = 4'd0;
        valE      = '0;
        valA      = '0;
        valP      = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        step();
        step();
        rst = 1'b0;
        step();

        // 1. reset state, stray ack in IDLE, no-access instruction
        check_idle_outputs("reset");
        check("reset_state", 64'(dbg_state), 64'd0);
        mem_ack   = 1'b1;
        mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        step();
        mem_ack = 1'b0;
        check("idle_ack_valm", valM, 64'd0);
        check("idle_ack_done", 64'(done), 64'd0);

        do_start(4'd6, 64'h100, 64'h1, 64'h2);
        check("opq_c1_done", 64'(done),       64'd1);
        check("opq_c1_req",  64'(mem_req),    64'd0);
        check("opq_c1_err",  64'(dmem_error), 64'd0);
        // start during the done cycle must be ignored
        start = 1'b1;
        icode = 4'd4;
        valE  = 64'h80;
        step();
        start = 1'b0;
        check("opq_c2_done", 64'(done),    64'd0);
        check("opq_c2_busy", 64'(busy),    64'd0);
        check("opq_c2_req",  64'(mem_req), 64'd0);
        step();
        check("opq_c3_req",  64'(mem_req), 64'd0);

        // 2. rmmovq, ack two cycles after request rises
        do_start(4'd4, 64'h100, 64'hDEAD_BEEF, 64'h0);
        check("rmm_c1_req",   64'(mem_req), 64'd1);
        check("rmm_c1_we",    64'(mem_we),  64'd1);
        check("rmm_c1_addr",  mem_addr,     64'h100);
        check("rmm_c1_wdata", mem_wdata,    64'hDEAD_BEEF);
        check("rmm_c1_busy",  64'(busy),    64'd1);
        step();
        check("rmm_c2_req",   64'(mem_req), 64'd1);
        check("rmm_c2_addr",  mem_addr,     64'h100);
        step();
        mem_ack = 1'b1;
        check("rmm_c3_req",   64'(mem_req), 64'd1);
        check("rmm_c3_wdata", mem_wdata,    64'hDEAD_BEEF);
        check("rmm_c3_done",  64'(done),    64'd0);
        step();
        mem_ack = 1'b0;
        check("rmm_c4_req",   64'(mem_req),    64'd0);
        check("rmm_c4_done",  64'(done),       64'd1);
        check("rmm_c4_err",   64'(dmem_error), 64'd0);
        step();
        check("rmm_c5_done",  64'(done), 64'd0);

        // 3. popq, ack in first request cycle
        exp_q.push_back(64'h1234);
        do_start(4'd11, 64'h9999, 64'h1F8, 64'h0);
        mem_ack   = 1'b1;
        mem_rdata = 64'h1234;
        check("pop_c1_req",  64'(mem_req), 64'd1);
        check("pop_c1_we",   64'(mem_we),  64'd0);
        check("pop_c1_addr", mem_addr,     64'h1F8);
        step();
        mem_ack   = 1'b0;
        mem_rdata = 64'h5555_AAAA;
        exp_v = exp_q.pop_front();
        check("pop_c2_done", 64'(done),    64'd1);
        check("pop_c2_req",  64'(mem_req), 64'd0);
        check("pop_c2_valm", valM,         exp_v);
        step();
        step();
        check("pop_valm_held", valM, exp_v);

        // 4. address boundary
        do_start(4'd5, 64'(MEM_SIZE - 7), 64'h0, 64'h0);
        check("oob1_done", 64'(done),       64'd1);
        check("oob1_err",  64'(dmem_error), 64'd1);
        check("oob1_req",  64'(mem_req),    64'd0);
        check("oob1_valm", valM,            64'd0);
        step();
        check("oob1_err_held", 64'(dmem_error), 64'd1);
        check("oob1_c2_req",   64'(mem_req),    64'd0);

        do_start(4'd5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0);
        check("oob2_done", 64'(done),       64'd1);
        check("oob2_err",  64'(dmem_error), 64'd1);
        check("oob2_req",  64'(mem_req),    64'd0);
        step();
        check("oob2_c2_req", 64'(mem_req), 64'd0);

        exp_q.push_back(64'hCAFE_F00D_0000_0001);
        do_start(4'd5, 64'(MEM_SIZE - 8), 64'h0, 64'h0);
        check("edge_c1_err",  64'(dmem_error), 64'd0);
        check("edge_c1_req",  64'(mem_req),    64'd1);
        check("edge_c1_addr", mem_addr,        64'(MEM_SIZE - 8));
        mem_ack   = 1'b1;
        mem_rdata = 64'hCAFE_F00D_0000_0001;
        step();
        mem_ack = 1'b0;
        exp_v = exp_q.pop_front();
        check("edge_c2_done", 64'(done), 64'd1);
        check("edge_c2_valm", valM,      exp_v);
        check("edge_c2_err",  64'(dmem_error), 64'd0);
        step();

        // 5. call with no ack -> timeout; start while busy is ignored
        do_start(4'd8, 64'h200, 64'h77, 64'h40);
        check("call_c1_we",    64'(mem_we), 64'd1);
        check("call_c1_wdata", mem_wdata,   64'h40);
        req_cycles = 0;
        done_cyc   = 0;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            if (mem_req) req_cycles++;
            if (done) done_cyc = c;
            if (c == 5) check("call_busy_addr", mem_addr, 64'h200);
            if (c == 3) begin
                start = 1'b1;
                icode = 4'd5;
                valE  = 64'h300;
            end else begin
                start = 1'b0;
            end
            if (done_cyc == 0) step();
        end
        start = 1'b0;
        check("to_done_cycle", 64'(done_cyc),   64'(TIMEOUT_CYC + 1));
        check("to_req_cycles", 64'(req_cycles), 64'(TIMEOUT_CYC));
        check("to_err",        64'(dmem_error), 64'd1);
        check("to_valm",       valM,            64'd0);
        step();
        check("to_after_busy", 64'(busy),       64'd0);
        check("to_after_err",  64'(dmem_error), 64'd1);
        check("to_after_req",  64'(mem_req),    64'd0);

        // 6. reset in the middle of a pushq access
        do_start(4'd10, 64'h80, 64'h55, 64'h0);
        check("push_c1_req", 64'(mem_req), 64'd1);
        step();
        #1 rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        step();
        rst = 1'b0;
        done_cyc = 0;
        for (int c = 0; c < 3; c++) begin
            if (done) done_cyc = 1;
            step();
        end
        check("midrst_no_done", 64'(done_cyc), 64'd0);

        do_start(4'd4, 64'h10, 64'h7, 64'h0);
        mem_ack = 1'b1;
        check("post_c1_req",   64'(mem_req), 64'd1);
        check("post_c1_wdata", mem_wdata,    64'h7);
        step();
        mem_ack = 1'b0;
        check("post_c2_done", 64'(done),       64'd1);
        check("post_c2_err",  64'(dmem_error), 64'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
